imem_boot_loader: RTL and testbench



---
 rtl/imem_loader_pkg.sv | 7 +
 rtl/imem_boot_loader_byte_packer.sv | 35 +++
 rtl/imem_boot_loader.sv | 93 +++++++++
 tb/tb_imem_boot_loader.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared states and byte-packing constants for the boot loader
package imem_loader_pkg;
  typedef enum logic [2:0] {HDR, DATA, WRITE, DONE, ERR} state_t;
  localparam int WORD_BYTES = 4;
  localparam int HDR_BYTES = 4;
  localparam int IDX_W = $clog2(WORD_BYTES);
endpackage

// File: rtl/imem_boot_loader_byte_packer.sv
// byte_packer: assembles four little-endian bytes into a 32-bit word
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_valid
);
  logic [IDX_W-1:0] idx;
  logic [31:0] buffer;
  // word already carries the byte being accepted, so the 4th byte completes it this cycle
  always_comb begin
    word = {idx == 2'd3 ? data : buffer[31:24],
            idx == 2'd2 ? data : buffer[23:16],
            idx == 2'd1 ? data : buffer[15:8],
            idx == 2'd0 ? data : buffer[7:0]};
    word_valid = en && idx == 2'd3;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
      buffer <= '0;
    end else if (clear) begin
      idx <= '0;
      buffer <= '0;
    end else if (en) begin
      idx <= idx + 1'b1;
      buffer <= word;
    end
  end
endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: loads a byte-streamed program into instruction memory, then hands
// the memory address port to the CPU fetch path
module imem_boot_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              reload,
  input  logic [ADDR_W-1:0] cpu_pc,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  output logic              cpu_stall,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] words_loaded
);
  state_t state;
  logic [ADDR_W-1:0] load_addr;
  logic [31:0] remaining, word;
  logic word_valid, fire;
  assign in_ready = state == HDR || state == DATA;
  assign fire = in_valid && in_ready;
  assign imem_addr = state == DONE ? cpu_pc : load_addr;
  byte_packer u_pack (
    .clk(clk),
    .rst(rst),
    .clear(state == DONE && reload),
    .en(fire),
    .data(in_data),
    .word(word),
    .word_valid(word_valid)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= HDR;
      mem_we <= 1'b0;
      mem_wdata <= '0;
      load_addr <= BASE_ADDR;
      remaining <= '0;
      words_loaded <= '0;
      cpu_stall <= 1'b1;
      done <= 1'b0;
      error <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        HDR: if (word_valid) begin
          if (word == '0) begin
            state <= DONE;
            cpu_stall <= 1'b0;
            done <= 1'b1;
          end else if (word > 32'(DEPTH_WORDS)) begin
            state <= ERR;
            error <= 1'b1;
          end else begin
            state <= DATA;
            remaining <= word;
          end
        end
        DATA: if (word_valid) begin
          state <= WRITE;
          mem_we <= 1'b1;
          mem_wdata <= word;
        end
        WRITE: begin
          load_addr <= load_addr + ADDR_W'(4);
          words_loaded <= words_loaded + ADDR_W'(1);
          remaining <= remaining - 32'd1;
          state <= remaining == 32'd1 ? DONE : DATA;
          cpu_stall <= remaining != 32'd1;
          done <= remaining == 32'd1;
        end
        DONE: if (reload) begin
          state <= HDR;
          cpu_stall <= 1'b1;
          done <= 1'b0;
          load_addr <= BASE_ADDR;
          words_loaded <= '0;
        end
        ERR: state <= ERR;
        default: state <= HDR;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: directed and randomized program loads checked against a write-list model
module tb_imem_boot_loader;
  logic clk = 1'b0;
  logic rst, in_valid, reload, in_ready, mem_we, cpu_stall, done, error;
  logic [7:0] in_data;
  logic [63:0] cpu_pc, imem_addr, words_loaded;
  logic [31:0] mem_wdata;
  int total = 0, bad = 0;
  logic [95:0] wq[$];
  logic [31:0] prog[$];
  localparam logic [63:0] BASE = 64'd0;

  imem_boot_loader dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .reload(reload), .cpu_pc(cpu_pc), .imem_addr(imem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .cpu_stall(cpu_stall), .done(done), .error(error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (!rst && mem_we) wq.push_back({imem_addr, mem_wdata});

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    in_valid = 1'b0;
    repeat (gap) begin
      @(negedge clk);
      in_data = 8'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data = b;
    n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gmax);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gmax == 0 ? 0 : int'($urandom_range(0, gmax)));
  endtask

  task automatic check_load(input int cnt);
    int n = 0;
    while (!done && !error && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("nwrites", 64'(wq.size()), 64'(cnt));
    for (int i = 0; i < cnt && i < wq.size(); i++) begin
      chk("waddr", wq[i][95:32], BASE + 64'(4 * i));
      chk("wdata", {32'd0, wq[i][31:0]}, {32'd0, prog[i]});
    end
    chk("done", {63'd0, done}, 64'd1);
    chk("stall_run", {63'd0, cpu_stall}, 64'd0);
    chk("error_run", {63'd0, error}, 64'd0);
    chk("words_loaded", words_loaded, 64'(cnt));
  endtask

  task automatic do_load(input int cnt, input int gmax);
    wq.delete();
    send_word(32'(cnt), gmax);
    foreach (prog[i]) send_word(prog[i], gmax);
    check_load(cnt);
  endtask

  task automatic rand_prog(input int cnt);
    prog.delete();
    for (int i = 0; i < cnt; i++) prog.push_back($urandom);
  endtask

  task automatic pulse_reload();
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    chk({tag, "_we"}, {63'd0, mem_we}, 64'd0);
    chk({tag, "_wdata"}, {32'd0, mem_wdata}, 64'd0);
    chk({tag, "_stall"}, {63'd0, cpu_stall}, 64'd1);
    chk({tag, "_done"}, {63'd0, done}, 64'd0);
    chk({tag, "_error"}, {63'd0, error}, 64'd0);
    chk({tag, "_words"}, words_loaded, 64'd0);
    chk({tag, "_addr"}, imem_addr, BASE);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; reload = 1'b0; cpu_pc = 64'h1234;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;

    prog = '{32'h00500093, 32'h00A00113};
    do_load(2, 0);
    cpu_pc = 64'd4;
    #1 chk("pc_mux4", imem_addr, 64'd4);
    cpu_pc = {$urandom, $urandom};
    #1 chk("pc_mux_rand", imem_addr, cpu_pc);

    pulse_reload();
    chk("reload_stall", {63'd0, cpu_stall}, 64'd1);
    chk("reload_done", {63'd0, done}, 64'd0);
    chk("reload_words", words_loaded, 64'd0);
    chk("reload_addr", imem_addr, BASE);
    rand_prog(1);
    wq.delete();
    send_word(32'd1, 0);
    send_byte(prog[0][7:0], 0);
    send_byte(prog[0][15:8], 0);
    pulse_reload();
    chk("reload_in_data_stall", {63'd0, cpu_stall}, 64'd1);
    send_byte(prog[0][23:16], 0);
    send_byte(prog[0][31:24], 0);
    check_load(1);

    for (int t = 0; t < 3; t++) begin
      pulse_reload();
      rand_prog(int'($urandom_range(1, 6)));
      do_load(prog.size(), 3);
    end

    pulse_reload();
    prog.delete();
    wq.delete();
    send_word(32'd0, 0);
    chk("zero_done", {63'd0, done}, 64'd1);
    check_load(0);

    pulse_reload();
    rand_prog(2);
    wq.delete();
    send_word(32'd2, 0);
    for (int k = 0; k < 4; k++) send_byte(prog[0][8*k +: 8], 1);
    chk("write_ready", {63'd0, in_ready}, 64'd0);
    chk("write_we", {63'd0, mem_we}, 64'd1);
    chk("write_addr", imem_addr, BASE);
    for (int k = 0; k < 4; k++) send_byte(prog[1][8*k +: 8], 0);
    check_load(2);

    pulse_reload();
    rand_prog(1);
    wq.delete();
    send_word(32'd1, 0);
    send_byte(8'hAA, 0);
    send_byte(8'h55, 0);
    @(negedge clk);
    rst = 1'b1;
    #1 check_reset_vals("midrst");
    @(negedge clk);
    rst = 1'b0;
    do_load(1, 0);

    pulse_reload();
    rand_prog(256);
    do_load(256, 0);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wq.delete();
    send_word(32'd257, 0);
    chk("ovf_error", {63'd0, error}, 64'd1);
    chk("ovf_ready", {63'd0, in_ready}, 64'd0);
    chk("ovf_stall", {63'd0, cpu_stall}, 64'd1);
    repeat (20) @(negedge clk);
    pulse_reload();
    chk("ovf_sticky", {63'd0, error}, 64'd1);
    chk("ovf_done", {63'd0, done}, 64'd0);
    chk("ovf_writes", 64'(wq.size()), 64'd0);
    rst = 1'b1;
    #1 chk("ovf_clear", {63'd0, error}, 64'd0);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
